// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int unsigned MAX_DIGITS = 8;

  // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the least significant slice.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Straight table lookup.
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking and
// frame-synchronous double-buffered display data.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  output logic [2:0]              sel_o,
  output logic                    digit_on_o,
  output logic [6:0]              seg_n_o,
  output logic                    dp_n_o,
  output logic                    frame_done_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > REFRESH_DIV - 1) begin : g_bad_blank_cycles
    $error("BLANK_CYCLES must be in 1 .. REFRESH_DIV-1");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 2 .. MAX_DIGITS");
  end

  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_d;
  scan_state_t               state;
  scan_state_t               state_d;
  logic [2:0]                sel_d;
  logic                      cnt_wrap;
  logic                      last_sel;
  logic                      boundary;

  logic [4*NUM_DIGITS-1:0]   stg_dig;
  logic [NUM_DIGITS-1:0]     stg_dp;
  logic [NUM_DIGITS-1:0]     stg_en;
  logic [4*NUM_DIGITS-1:0]   shd_dig;
  logic [NUM_DIGITS-1:0]     shd_dp;
  logic [NUM_DIGITS-1:0]     shd_en;
  logic [4*NUM_DIGITS-1:0]   shd_dig_d;
  logic [NUM_DIGITS-1:0]     shd_dp_d;
  logic [NUM_DIGITS-1:0]     shd_en_d;

  logic [3:0]                nib;
  logic [6:0]                hex_seg;

  // Next-cycle slot counter, digit index, state and shadow contents.
  // Outputs are built from these next values so the registered outputs
  // line up with the registered counter/state in the same cycle.
  // Shadow is also rewritten on a load during the frame_done_o cycle: that
  // cycle is still inside digit 0's blanking, so the newest data wins
  // without tearing the visible frame.
  always_comb begin
    cnt_wrap = (cnt == CW'(REFRESH_DIV - 1));
    last_sel = (sel_o == 3'(NUM_DIGITS - 1));
    boundary = cnt_wrap && last_sel;
    cnt_d    = cnt_wrap ? '0 : cnt + 1'b1;
    sel_d    = sel_o;
    if (cnt_wrap) begin
      sel_d = last_sel ? '0 : sel_o + 3'd1;
    end
    state_d = state;
    if (state == BLANK) begin
      if (cnt == CW'(BLANK_CYCLES - 1)) state_d = ON;
    end else begin
      if (cnt_wrap) state_d = BLANK;
    end
    shd_dig_d = shd_dig;
    shd_dp_d  = shd_dp;
    shd_en_d  = shd_en;
    if (boundary) begin
      shd_dig_d = load_i ? digits_i : stg_dig;
      shd_dp_d  = load_i ? dp_i     : stg_dp;
      shd_en_d  = load_i ? en_i     : stg_en;
    end else if (frame_done_o && load_i) begin
      shd_dig_d = digits_i;
      shd_dp_d  = dp_i;
      shd_en_d  = en_i;
    end
    nib = shd_dig_d[4*sel_d +: 4];
  end

  hex_to_seg u_hex (
    .nib (nib),
    .seg (hex_seg)
  );

  // Staging captures every load; shadow follows the frame-boundary rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_dig <= '0;
      stg_dp  <= '0;
      stg_en  <= '0;
      shd_dig <= '0;
      shd_dp  <= '0;
      shd_en  <= '0;
    end else begin
      if (load_i) begin
        stg_dig <= digits_i;
        stg_dp  <= dp_i;
        stg_en  <= en_i;
      end
      shd_dig <= shd_dig_d;
      shd_dp  <= shd_dp_d;
      shd_en  <= shd_en_d;
    end
  end

  // Scan FSM with registered anode/cathode outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      state        <= BLANK;
      sel_o        <= '0;
      digit_on_o   <= 1'b0;
      seg_n_o      <= SEG_OFF;
      dp_n_o       <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      state        <= state_d;
      sel_o        <= sel_d;
      frame_done_o <= boundary;
      if (state_d == ON) begin
        digit_on_o <= 1'b1;
        if (shd_en_d[sel_d]) begin
          seg_n_o <= hex_seg;
          dp_n_o  <= ~shd_dp_d[sel_d];
        end else begin
          seg_n_o <= SEG_OFF;
          dp_n_o  <= 1'b1;
        end
      end else begin
        digit_on_o <= 1'b0;
        seg_n_o    <= SEG_OFF;
        dp_n_o     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a short refresh period.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned ND = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_i = 1'b0;
  logic [31:0] digits_i = '0;
  logic [7:0]  dp_i = '0;
  logic [7:0]  en_i = '0;
  logic [2:0]  sel_o;
  logic        digit_on_o;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;
  logic        frame_done_o;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .NUM_DIGITS   (ND)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_i),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .en_i         (en_i),
    .sel_o        (sel_o),
    .digit_on_o   (digit_on_o),
    .seg_n_o      (seg_n_o),
    .dp_n_o       (dp_n_o),
    .frame_done_o (frame_done_o)
  );

  int          total = 0;
  int          bad = 0;
  int unsigned cur = 0;
  logic [2:0]  prev_sel = '0;

  typedef struct {
    int unsigned k;
    bit          ld;
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [2:0]  sel;
    bit          on;
    logic [6:0]  seg;
    bit          dpn;
    bit          fd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int unsigned k, input bit ld, input logic [31:0] dig,
                              input logic [7:0] dp, input logic [7:0] en, input logic [2:0] sel,
                              input bit on, input logic [6:0] seg, input bit dpn, input bit fd);
    vec_t v;
    v.k = k; v.ld = ld; v.dig = dig; v.dp = dp; v.en = en;
    v.sel = sel; v.on = on; v.seg = seg; v.dpn = dpn; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", nm, cur, got, exp);
    end
  endtask

  task automatic check_outs(input logic [2:0] sel, input bit on, input logic [6:0] seg,
                            input bit dpn, input bit fd);
    chk("sel_o", {29'b0, sel_o}, {29'b0, sel});
    chk("digit_on_o", {31'b0, digit_on_o}, {31'b0, on});
    chk("seg_n_o", {25'b0, seg_n_o}, {25'b0, seg});
    chk("dp_n_o", {31'b0, dp_n_o}, {31'b0, dpn});
    chk("frame_done_o", {31'b0, frame_done_o}, {31'b0, fd});
  endtask

  task automatic apply_load(input logic [31:0] dig, input logic [7:0] dp, input logic [7:0] en);
    load_i   = 1'b1;
    digits_i = dig;
    dp_i     = dp;
    en_i     = en;
  endtask

  // One clock: the DUT sees this cycle's inputs at the posedge, outputs are read at the negedge.
  task automatic step();
    @(negedge clk);
    cur++;
    load_i = 1'b0;
    if (sel_o !== prev_sel) chk("sel_change_blanked", {31'b0, digit_on_o}, 32'd0);
    prev_sel = sel_o;
  endtask

  task automatic advance(input int unsigned target);
    while (cur < target) step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    // k = posedges since reset release; slot = k%8, digit = (k/8)%8, frame = k/64
    vq.push_back(mk(  1, 0, 32'h0, 8'h00, 8'h00, 3'd0, 0, 7'h7F, 1, 0));
    vq.push_back(mk(  2, 0, 32'h0, 8'h00, 8'h00, 3'd0, 1, 7'h7F, 1, 0));
    vq.push_back(mk(  7, 0, 32'h0, 8'h00, 8'h00, 3'd0, 1, 7'h7F, 1, 0));
    vq.push_back(mk(  8, 0, 32'h0, 8'h00, 8'h00, 3'd1, 0, 7'h7F, 1, 0));
    vq.push_back(mk( 10, 0, 32'h0, 8'h00, 8'h00, 3'd1, 1, 7'h7F, 1, 0));
    vq.push_back(mk( 63, 0, 32'h0, 8'h00, 8'h00, 3'd7, 1, 7'h7F, 1, 0));
    vq.push_back(mk( 64, 0, 32'h0, 8'h00, 8'h00, 3'd0, 0, 7'h7F, 1, 1));
    vq.push_back(mk( 65, 0, 32'h0, 8'h00, 8'h00, 3'd0, 0, 7'h7F, 1, 0));
    vq.push_back(mk( 70, 1, 32'h7654_3210, 8'h01, 8'hFF, 3'd0, 1, 7'h7F, 1, 0));
    vq.push_back(mk(128, 0, 32'h0, 8'h00, 8'h00, 3'd0, 0, 7'h7F, 1, 1));
    vq.push_back(mk(130, 0, 32'h0, 8'h00, 8'h00, 3'd0, 1, 7'h40, 0, 0));
    vq.push_back(mk(154, 0, 32'h0, 8'h00, 8'h00, 3'd3, 1, 7'h30, 1, 0));
    vq.push_back(mk(163, 1, 32'hFFFF_FFFF, 8'h00, 8'hFF, 3'd4, 1, 7'h19, 1, 0));
    vq.push_back(mk(191, 0, 32'h0, 8'h00, 8'h00, 3'd7, 1, 7'h78, 1, 0));
    vq.push_back(mk(192, 0, 32'h0, 8'h00, 8'h00, 3'd0, 0, 7'h7F, 1, 1));
    vq.push_back(mk(194, 0, 32'h0, 8'h00, 8'h00, 3'd0, 1, 7'h0E, 1, 0));
    vq.push_back(mk(236, 0, 32'h0, 8'h00, 8'h00, 3'd5, 1, 7'h0E, 1, 0));
    vq.push_back(mk(258, 1, 32'h7654_3210, 8'hFF, 8'h0F, 3'd0, 1, 7'h40, 0, 0));
    vq.push_back(mk(290, 0, 32'h0, 8'h00, 8'h00, 3'd4, 1, 7'h7F, 1, 0));
    vq.push_back(mk(319, 0, 32'h0, 8'h00, 8'h00, 3'd7, 1, 7'h7F, 1, 0));
    vq.push_back(mk(320, 0, 32'h0, 8'h00, 8'h00, 3'd0, 0, 7'h7F, 1, 1));
    vq.push_back(mk(322, 1, 32'hAAAA_AAAA, 8'h00, 8'hFF, 3'd0, 1, 7'h08, 1, 0));
    vq.push_back(mk(330, 0, 32'h0, 8'h00, 8'h00, 3'd1, 1, 7'h08, 1, 0));

    // asynchronous reset values before any clock edge
    #1 rst = 1'b1;
    #2;
    check_outs(3'd0, 0, 7'h7F, 1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur = 0;
    prev_sel = '0;

    foreach (vq[i]) begin
      if (vq[i].ld) apply_load(vq[i].dig, vq[i].dp, vq[i].en);
      advance(vq[i].k);
      check_outs(vq[i].sel, vq[i].on, vq[i].seg, vq[i].dpn, vq[i].fd);
    end

    // back-to-back loads: the later one is shown next frame
    apply_load(32'h1111_1111, 8'h00, 8'hFF);
    step();
    apply_load(32'h2222_2222, 8'h00, 8'hFF);
    step();
    advance(386);
    check_outs(3'd0, 1, 7'h24, 1, 0);

    // load on the cycle whose closing edge is the frame boundary
    advance(447);
    apply_load(32'h3333_3333, 8'h00, 8'hFF);
    advance(448);
    check_outs(3'd0, 0, 7'h7F, 1, 1);
    advance(450);
    check_outs(3'd0, 1, 7'h30, 1, 0);

    // reset in the middle of an ON slot
    advance(468);
    check_outs(3'd2, 1, 7'h30, 1, 0);
    rst = 1'b1;
    #1;
    check_outs(3'd0, 0, 7'h7F, 1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur = 0;
    prev_sel = '0;
    advance(1);
    check_outs(3'd0, 0, 7'h7F, 1, 0);
    advance(2);
    check_outs(3'd0, 1, 7'h7F, 1, 0);
    // staging was cleared too, so the next frame is still blank
    advance(66);
    check_outs(3'd0, 1, 7'h7F, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
